// File: rtl/siso_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : siso_frame_pkg
//  Description : Shared state encoding and parity helper for siso_frame_ctrl.
//  Revision    : 1.0
// ============================================================================
package siso_frame_pkg;

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_SHIFT  = 2'd1;
   localparam logic [1:0] c_ST_PARITY = 2'd2;
   localparam logic [1:0] c_ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = c_ST_IDLE,
      SHIFT  = c_ST_SHIFT,
      PARITY = c_ST_PARITY,
      DONE   = c_ST_DONE
   } frame_state_t;

   // Even parity over a word zero-extended to 64 bits.
   function automatic logic parity_f(input logic [63:0] v);
      return ^v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/siso_frame_if.sv
`default_nettype none
// ============================================================================
//  Module      : siso_frame_if
//  Description : Parallel handshake plus serial chain signals of siso_frame_ctrl.
//                parity_err exists only when SISO_FRAME_PARITY_EN is defined.
//  Revision    : 1.0
// ============================================================================
interface siso_frame_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             si;
   logic             so;
   logic             shift_en;
   logic             busy;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
`ifdef SISO_FRAME_PARITY_EN
   logic             parity_err;

   modport master (output tx_data, tx_valid, si,
                   input  tx_ready, so, shift_en, busy, rx_data, rx_valid, parity_err);
   modport slave  (input  tx_data, tx_valid, si,
                   output tx_ready, so, shift_en, busy, rx_data, rx_valid, parity_err);
`else
   modport master (output tx_data, tx_valid, si,
                   input  tx_ready, so, shift_en, busy, rx_data, rx_valid);
   modport slave  (input  tx_data, tx_valid, si,
                   output tx_ready, so, shift_en, busy, rx_data, rx_valid);
`endif
endinterface
`default_nettype wire

// File: rtl/siso_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : siso_bit_timer
//  Description : Bit-period divider; tick marks the last cycle of each period.
//  Revision    : 1.0
// ============================================================================
module siso_bit_timer #(
   parameter int DIV = 1
) (
   input  wire  clk,
   input  wire  clear_n,
   input  wire  run,
   output logic tick
);
   localparam int              c_CW   = $clog2(DIV + 1);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

   logic [c_CW-1:0] r_div_cnt;

   assign tick = run && (r_div_cnt == c_LAST);

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_div_cnt <= '0;
      end else if (!run || tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + c_CW'(1);
      end
   end
endmodule
`default_nettype wire

// File: rtl/siso_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : siso_frame_ctrl
//  Description : Frames a parallel word out MSB-first on so while capturing si.
//                Optional trailing parity bit with SISO_FRAME_PARITY_EN.
//  Revision    : 1.0
// ============================================================================
module siso_frame_ctrl
   import siso_frame_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input wire          clk,
   input wire          clear_n,
   siso_frame_if.slave bus
);
   localparam int             c_CW       = $clog2(WIDTH);
   localparam logic [c_CW-1:0] c_LAST_BIT = c_CW'(WIDTH - 1);
`ifdef SISO_FRAME_PARITY_EN
   localparam int             c_RXW      = WIDTH;
`else
   // Without parity the final si bit goes straight into rx_data, so one bit less is stored.
   localparam int             c_RXW      = WIDTH - 1;
`endif

   frame_state_t     r_state;
   frame_state_t     w_next;
   logic [WIDTH-2:0] r_tx;
   logic [c_RXW-1:0] r_rx;
   logic [WIDTH-1:0] r_rx_data;
   logic [c_CW-1:0]  r_bit_cnt;
   logic             r_so;
   logic             w_run;
   logic             w_tick;
   logic             w_accept;
   logic             w_last_bit;
`ifdef SISO_FRAME_PARITY_EN
   logic             r_par;
   logic             r_parity_err;
   assign bus.parity_err = r_parity_err;
`endif

   assign w_run      = (r_state == SHIFT) || (r_state == PARITY);
   assign w_accept   = bus.tx_valid && (r_state == IDLE);
   assign w_last_bit = (r_bit_cnt == c_LAST_BIT);
   assign bus.so      = r_so;
   assign bus.rx_data = r_rx_data;

   siso_bit_timer #(.DIV(DIV)) u_timer (
      .clk     (clk),
      .clear_n (clear_n),
      .run     (w_run),
      .tick    (w_tick)
   );

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      bus.busy     = (r_state != IDLE);
      bus.rx_valid = (r_state == DONE);
      bus.tx_ready = clear_n && (r_state == IDLE);
      bus.shift_en = w_tick;
      case (r_state)
         IDLE:    if (w_accept) w_next = SHIFT;
`ifdef SISO_FRAME_PARITY_EN
         SHIFT:   if (w_tick && w_last_bit) w_next = PARITY;
`else
         SHIFT:   if (w_tick && w_last_bit) w_next = DONE;
`endif
         PARITY:  if (w_tick) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_tx      <= '0;
         r_rx      <= '0;
         r_rx_data <= '0;
         r_bit_cnt <= '0;
         r_so      <= 1'b0;
`ifdef SISO_FRAME_PARITY_EN
         r_par        <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_tx      <= bus.tx_data[WIDTH-2:0];
               r_so      <= bus.tx_data[WIDTH-1];
               r_bit_cnt <= '0;
`ifdef SISO_FRAME_PARITY_EN
               r_par     <= parity_f(64'(bus.tx_data));
`endif
            end
            SHIFT: if (w_tick) begin
               r_rx <= c_RXW'({r_rx, bus.si});
               r_tx <= r_tx << 1;
               if (w_last_bit) begin
`ifdef SISO_FRAME_PARITY_EN
                  r_so      <= r_par;
`else
                  r_so      <= 1'b0;
                  r_rx_data <= {r_rx, bus.si};
`endif
               end else begin
                  r_so      <= r_tx[WIDTH-2];
                  r_bit_cnt <= r_bit_cnt + c_CW'(1);
               end
            end
`ifdef SISO_FRAME_PARITY_EN
            PARITY: if (w_tick) begin
               r_so         <= 1'b0;
               r_rx_data    <= r_rx;
               r_parity_err <= bus.si ^ parity_f(64'(r_rx));
            end
`endif
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire
